// File: rtl/best_arr_sender.sv
// Serializes the final best-match index array into the output FIFO in the
// host's blocked order (px half, x block, row y, xi), with a 2-entry skid buffer.
module best_arr_sender #(
  parameter int DATA_WIDTH = 11,
  parameter int IDX_WIDTH  = 9,
  parameter int ROW_SIZE   = 26,
  parameter int COL_SIZE   = 19,
  parameter int BLOCKING   = 4,
  parameter int NUM_QUERYS = ROW_SIZE * COL_SIZE,
  parameter int ADDR_WIDTH = $clog2(NUM_QUERYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  send_best_arr,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [IDX_WIDTH-1:0]  mem_rd_data,
  output logic                  out_fifo_wenq,
  output logic [DATA_WIDTH-1:0] out_fifo_wdata,
  input  logic                  out_fifo_wfull_n
);

  localparam int HALF  = ROW_SIZE / 2;
  localparam int NUM_X = (HALF + BLOCKING - 1) / BLOCKING;
  localparam int XW    = (NUM_X > 1) ? $clog2(NUM_X) : 1;
  localparam int YW    = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
  localparam int XIW   = (BLOCKING > 1) ? $clog2(BLOCKING) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic                    px_reg, px_next;
  logic [XW-1:0]           x_reg, x_next;
  logic [YW-1:0]           y_reg, y_next;
  logic [XIW-1:0]          xi_reg, xi_next;
  logic                    mem_rd_en_reg, mem_rd_en_next;
  logic [ADDR_WIDTH-1:0]   mem_rd_addr_reg, mem_rd_addr_next;
  logic                    rd_valid_reg, rd_valid_next;
  logic [1:0]              cnt_reg, cnt_next;
  logic [IDX_WIDTH-1:0]    buf_reg [2];
  logic [IDX_WIDTH-1:0]    buf_next [2];
  logic                    out_fifo_wenq_reg, out_fifo_wenq_next;
  logic [DATA_WIDTH-1:0]   out_fifo_wdata_reg, out_fifo_wdata_next;

  logic                    push, pop, room, issue, from_idle;
  logic                    xi_wrap, y_wrap, x_wrap, last_combo;
  logic [IDX_WIDTH-1:0]    head;
  logic                    cur_px;
  logic [XW-1:0]           cur_x;
  logic [YW-1:0]           cur_y;
  logic [XIW-1:0]          cur_xi;
  int                      col_calc, addr_calc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= S_IDLE;
      px_reg             <= 1'b0;
      x_reg              <= '0;
      y_reg              <= '0;
      xi_reg             <= '0;
      mem_rd_en_reg      <= 1'b0;
      mem_rd_addr_reg    <= '0;
      rd_valid_reg       <= 1'b0;
      cnt_reg            <= 2'd0;
      buf_reg[0]         <= '0;
      buf_reg[1]         <= '0;
      out_fifo_wenq_reg  <= 1'b0;
      out_fifo_wdata_reg <= '0;
    end else begin
      state_reg          <= state_next;
      px_reg             <= px_next;
      x_reg              <= x_next;
      y_reg              <= y_next;
      xi_reg             <= xi_next;
      mem_rd_en_reg      <= mem_rd_en_next;
      mem_rd_addr_reg    <= mem_rd_addr_next;
      rd_valid_reg       <= rd_valid_next;
      cnt_reg            <= cnt_next;
      buf_reg[0]         <= buf_next[0];
      buf_reg[1]         <= buf_next[1];
      out_fifo_wenq_reg  <= out_fifo_wenq_next;
      out_fifo_wdata_reg <= out_fifo_wdata_next;
    end
  end

  always_comb begin
    state_next          = state_reg;
    px_next             = px_reg;
    x_next              = x_reg;
    y_next              = y_reg;
    xi_next             = xi_reg;
    mem_rd_en_next      = 1'b0;
    mem_rd_addr_next    = mem_rd_addr_reg;
    rd_valid_next       = mem_rd_en_reg;
    cnt_next            = cnt_reg;
    buf_next[0]         = buf_reg[0];
    buf_next[1]         = buf_reg[1];
    issue               = 1'b0;

    // Returning read data bypasses straight to the output when the buffer is empty.
    push = rd_valid_reg;
    pop  = out_fifo_wfull_n && ((cnt_reg != 2'd0) || push);
    head = (cnt_reg != 2'd0) ? buf_reg[0] : mem_rd_data;
    out_fifo_wenq_next  = pop;
    out_fifo_wdata_next = pop ? DATA_WIDTH'(head) : out_fifo_wdata_reg;

    case (cnt_reg)
      2'd0: begin
        if (push && !pop) begin
          buf_next[0] = mem_rd_data;
          cnt_next    = 2'd1;
        end
      end
      2'd1: begin
        if (pop && push) begin
          buf_next[0] = mem_rd_data;
        end else if (pop) begin
          cnt_next = 2'd0;
        end else if (push) begin
          buf_next[1] = mem_rd_data;
          cnt_next    = 2'd2;
        end
      end
      default: begin
        if (pop) begin
          buf_next[0] = buf_reg[1];
          if (push) buf_next[1] = mem_rd_data;
          else      cnt_next    = 2'd1;
        end
      end
    endcase

    // The first read is issued straight from IDLE so it lands one cycle after the start pulse.
    from_idle = (state_reg == S_IDLE);
    cur_px    = from_idle ? 1'b0 : px_reg;
    cur_x     = from_idle ? '0   : x_reg;
    cur_y     = from_idle ? '0   : y_reg;
    cur_xi    = from_idle ? '0   : xi_reg;

    col_calc   = int'(cur_x) * BLOCKING + int'(cur_xi);
    addr_calc  = int'(cur_px) * HALF + int'(cur_y) * ROW_SIZE + col_calc;
    xi_wrap    = (cur_xi == XIW'(BLOCKING - 1)) || (col_calc + 1 >= HALF);
    y_wrap     = (cur_y == YW'(COL_SIZE - 1));
    x_wrap     = (cur_x == XW'(NUM_X - 1));
    last_combo = cur_px && x_wrap && y_wrap && xi_wrap;

    // Occupancy plus the read still in flight must leave space for the new one.
    room = (cnt_next + {1'b0, mem_rd_en_reg}) < 2'd2;

    case (state_reg)
      S_IDLE: begin
        if (send_best_arr) begin
          issue      = 1'b1;
          state_next = last_combo ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (room) begin
          issue = 1'b1;
          if (last_combo) state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((cnt_reg == 2'd0) && !rd_valid_reg && !mem_rd_en_reg) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    if (issue) begin
      mem_rd_en_next   = 1'b1;
      mem_rd_addr_next = ADDR_WIDTH'(addr_calc);
      px_next          = cur_px;
      x_next           = cur_x;
      y_next           = cur_y;
      xi_next          = cur_xi + XIW'(1);
      if (xi_wrap) begin
        xi_next = '0;
        y_next  = cur_y + YW'(1);
        if (y_wrap) begin
          y_next = '0;
          x_next = cur_x + XW'(1);
          if (x_wrap) begin
            x_next  = '0;
            px_next = ~cur_px;
          end
        end
      end
    end
  end

  assign busy           = (state_reg == S_RUN) || (state_reg == S_DRAIN);
  assign done           = (state_reg == S_DONE);
  assign mem_rd_en      = mem_rd_en_reg;
  assign mem_rd_addr    = mem_rd_addr_reg;
  assign out_fifo_wenq  = out_fifo_wenq_reg;
  assign out_fifo_wdata = out_fifo_wdata_reg;

endmodule

// File: tb/tb_best_arr_sender.sv
// Directed bench for best_arr_sender: memory returns data = address, FIFO sink logs every enqueue.
module tb_best_arr_sender;

  localparam int NQ = 494;

  logic        clk = 1'b0;
  logic        rst;
  logic        send_best_arr;
  logic        busy, done, mem_rd_en;
  logic [8:0]  mem_rd_addr;
  logic [8:0]  mem_rd_data = '0;
  logic        out_fifo_wenq;
  logic [10:0] out_fifo_wdata;
  logic        out_fifo_wfull_n;

  int n_checks = 0;
  int n_pass   = 0;

  int cyc = 0;
  logic wfull_at_edge = 1'b1;
  logic busy_prev = 1'b0;
  int gap_viol = 0;
  int done_cnt = 0;
  int busy_bad = 0;
  int os_offset = 0;
  int max_os = 0;

  logic [8:0]  rd_q[$];
  int          rd_cyc_q[$];
  logic [10:0] wr_q[$];
  int          wr_cyc_q[$];
  int          exp_addr[NQ];
  int          t_start;

  always #5 clk = ~clk;

  best_arr_sender dut (
    .clk(clk), .rst(rst), .send_best_arr(send_best_arr), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_fifo_wenq(out_fifo_wenq), .out_fifo_wdata(out_fifo_wdata),
    .out_fifo_wfull_n(out_fifo_wfull_n)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    wfull_at_edge <= out_fifo_wfull_n;
    if (mem_rd_en) mem_rd_data <= mem_rd_addr;
  end

  always @(negedge clk) begin
    if (mem_rd_en) begin
      rd_q.push_back(mem_rd_addr);
      rd_cyc_q.push_back(cyc);
    end
    if (out_fifo_wenq) begin
      wr_q.push_back(out_fifo_wdata);
      wr_cyc_q.push_back(cyc);
      if (!wfull_at_edge) gap_viol <= gap_viol + 1;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      if (busy || !busy_prev) busy_bad <= busy_bad + 1;
    end
    busy_prev <= busy;
    if (rst) os_offset <= rd_q.size() - wr_q.size();
    else if (rd_q.size() - wr_q.size() - os_offset > max_os)
      max_os <= rd_q.size() - wr_q.size() - os_offset;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int seq_errors(int wb);
    int e = 0;
    for (int i = 0; i < NQ; i++) begin
      if (wb + i >= wr_q.size()) e++;
      else if (int'(wr_q[wb + i]) != exp_addr[i]) e++;
    end
    if (wr_q.size() - wb != NQ) e++;
    return e;
  endfunction

  task automatic start_xfer();
    @(posedge clk); #1 send_best_arr = 1'b1;
    @(posedge clk); #1 send_best_arr = 1'b0;
    t_start = cyc;
  endtask

  task automatic wait_done(input int db, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk); #1;
      if (done_cnt > db) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if ({busy, done, mem_rd_en, out_fifo_wenq} !== 4'b0) $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, mem_rd_en, out_fifo_wenq}); else n_pass++;
    n_checks++; if (mem_rd_addr !== 9'd0) $display("FAIL reset_addr: got %0d expected 0", mem_rd_addr); else n_pass++;
    n_checks++; if (out_fifo_wdata !== 11'd0) $display("FAIL reset_wdata: got %0d expected 0", out_fifo_wdata); else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (rd_q.size() != 0) $display("FAIL idle_no_reads: got %0d expected 0", rd_q.size()); else n_pass++;
  endtask

  task automatic test_full_transfer();
    int rb, wb, db, bb, e;
    bit ok;
    bit seen[NQ];
    int first8[8] = '{0, 1, 2, 3, 26, 27, 28, 29};
    rb = rd_q.size(); wb = wr_q.size(); db = done_cnt; bb = busy_bad;
    start_xfer();
    wait_done(db, ok);
    n_checks++; if (!ok) $display("FAIL full_done_timeout: got 0 expected 1"); else n_pass++;
    n_checks++; if (rd_q.size() - rb != NQ) $display("FAIL full_reads: got %0d expected %0d", rd_q.size() - rb, NQ); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (int'(rd_q[rb + i]) != first8[i]) $display("FAIL first_addr[%0d]: got %0d expected %0d", i, rd_q[rb + i], first8[i]); else n_pass++;
    end
    n_checks++; if (rd_q[rb + 228] !== 9'd12) $display("FAIL x3_first: got %0d expected 12", rd_q[rb + 228]); else n_pass++;
    n_checks++; if (rd_q[rb + 229] !== 9'd38) $display("FAIL x3_second: got %0d expected 38", rd_q[rb + 229]); else n_pass++;
    n_checks++; if (rd_q[rb + 247] !== 9'd13) $display("FAIL px1_start: got %0d expected 13", rd_q[rb + 247]); else n_pass++;
    n_checks++; if (rd_q[rb + 493] !== 9'd493) $display("FAIL last_addr: got %0d expected 493", rd_q[rb + 493]); else n_pass++;
    n_checks++; if (wr_q.size() - wb != NQ) $display("FAIL full_enqs: got %0d expected %0d", wr_q.size() - wb, NQ); else n_pass++;
    n_checks++; if (done_cnt - db != 1) $display("FAIL done_pulses: got %0d expected 1", done_cnt - db); else n_pass++;
    n_checks++; if (busy_bad != bb) $display("FAIL busy_with_done: got %0d bad expected 0", busy_bad - bb); else n_pass++;
    e = seq_errors(wb);
    n_checks++; if (e != 0) $display("FAIL full_order: got %0d errors expected 0", e); else n_pass++;
    e = 0;
    for (int i = 0; i < NQ; i++) begin
      int v = int'(wr_q[wb + i]);
      if (v >= NQ || seen[v]) e++;
      else seen[v] = 1'b1;
    end
    n_checks++; if (e != 0) $display("FAIL deserialized_set: got %0d bad words expected 0", e); else n_pass++;
    n_checks++; if (rd_cyc_q[rb] != t_start) $display("FAIL rd_latency: got %0d expected %0d", rd_cyc_q[rb] - t_start + 1, 1); else n_pass++;
    n_checks++; if (wr_cyc_q[wb] != t_start + 2) $display("FAIL wenq_latency: got %0d expected %0d", wr_cyc_q[wb] - t_start + 1, 3); else n_pass++;
    n_checks++; if (wr_cyc_q[wb + NQ - 1] - wr_cyc_q[wb] != NQ - 1) $display("FAIL sustained_rate: got span %0d expected %0d", wr_cyc_q[wb + NQ - 1] - wr_cyc_q[wb], NQ - 1); else n_pass++;
  endtask

  task automatic test_backpressure();
    int rb, wb, db, gv, c, e, rd_in_gap;
    bit ok;
    rb = rd_q.size(); wb = wr_q.size(); db = done_cnt; gv = gap_viol;
    start_xfer();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (wr_q.size() - wb >= 6) break;
    end
    c = wr_cyc_q[wb + 5];
    out_fifo_wfull_n = 1'b0;
    repeat (10) @(posedge clk);
    #1 out_fifo_wfull_n = 1'b1;
    wait_done(db, ok);
    n_checks++; if (!ok) $display("FAIL bp_done_timeout: got 0 expected 1"); else n_pass++;
    n_checks++; if (gap_viol != gv) $display("FAIL bp_enq_while_full: got %0d expected 0", gap_viol - gv); else n_pass++;
    n_checks++; if (wr_cyc_q[wb + 6] - c != 11) $display("FAIL bp_resume: got gap %0d expected 11", wr_cyc_q[wb + 6] - c); else n_pass++;
    rd_in_gap = 0;
    for (int i = rb; i < rd_q.size(); i++)
      if (rd_cyc_q[i] > c && rd_cyc_q[i] <= c + 10) rd_in_gap++;
    n_checks++; if (rd_in_gap != 0) $display("FAIL bp_reads_stop: got %0d expected 0", rd_in_gap); else n_pass++;
    n_checks++; if (max_os > 2) $display("FAIL bp_outstanding: got %0d expected <=2", max_os); else n_pass++;
    e = seq_errors(wb);
    n_checks++; if (e != 0) $display("FAIL bp_order: got %0d errors expected 0", e); else n_pass++;
  endtask

  task automatic test_random_backpressure();
    int wb, db, gv, e;
    bit ok;
    wb = wr_q.size(); db = done_cnt; gv = gap_viol; ok = 1'b0;
    start_xfer();
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1 out_fifo_wfull_n = 1'($urandom_range(0, 1));
      if (done_cnt > db) begin
        ok = 1'b1;
        break;
      end
    end
    out_fifo_wfull_n = 1'b1;
    n_checks++; if (!ok) $display("FAIL rnd_done_timeout: got 0 expected 1"); else n_pass++;
    n_checks++; if (gap_viol != gv) $display("FAIL rnd_enq_while_full: got %0d expected 0", gap_viol - gv); else n_pass++;
    n_checks++; if (max_os > 2) $display("FAIL rnd_outstanding: got %0d expected <=2", max_os); else n_pass++;
    e = seq_errors(wb);
    n_checks++; if (e != 0) $display("FAIL rnd_order: got %0d errors expected 0", e); else n_pass++;
  endtask

  task automatic test_extra_start();
    int rb, wb, db, e;
    bit ok;
    rb = rd_q.size(); wb = wr_q.size(); db = done_cnt;
    start_xfer();
    repeat (50) @(posedge clk);
    #1 send_best_arr = 1'b1;
    @(posedge clk); #1 send_best_arr = 1'b0;
    wait_done(db, ok);
    repeat (30) @(posedge clk);
    #1;
    n_checks++; if (!ok) $display("FAIL extra_done_timeout: got 0 expected 1"); else n_pass++;
    n_checks++; if (rd_q.size() - rb != NQ) $display("FAIL extra_reads: got %0d expected %0d", rd_q.size() - rb, NQ); else n_pass++;
    n_checks++; if (done_cnt - db != 1) $display("FAIL extra_done_pulses: got %0d expected 1", done_cnt - db); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL extra_busy_after: got %b expected 0", busy); else n_pass++;
    e = seq_errors(wb);
    n_checks++; if (e != 0) $display("FAIL extra_order: got %0d errors expected 0", e); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int wb, rb, db, e;
    bit ok;
    wb = wr_q.size(); db = done_cnt;
    start_xfer();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (wr_q.size() - wb >= 100) break;
    end
    rst = 1'b1;
    #1;
    n_checks++; if ({busy, done, mem_rd_en, out_fifo_wenq} !== 4'b0) $display("FAIL midrst_ctrl: got %b expected 0000", {busy, done, mem_rd_en, out_fifo_wenq}); else n_pass++;
    n_checks++; if (mem_rd_addr !== 9'd0 || out_fifo_wdata !== 11'd0) $display("FAIL midrst_data: got addr %0d wdata %0d expected 0 0", mem_rd_addr, out_fifo_wdata); else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rb = rd_q.size();
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (rd_q.size() != rb || done_cnt != db) $display("FAIL midrst_idle: got %0d reads %0d dones expected 0 0", rd_q.size() - rb, done_cnt - db); else n_pass++;
    wb = wr_q.size();
    start_xfer();
    wait_done(db, ok);
    n_checks++; if (!ok) $display("FAIL restart_done_timeout: got 0 expected 1"); else n_pass++;
    n_checks++; if (rd_q[rb] !== 9'd0) $display("FAIL restart_addr0: got %0d expected 0", rd_q[rb]); else n_pass++;
    e = seq_errors(wb);
    n_checks++; if (e != 0) $display("FAIL restart_order: got %0d errors expected 0", e); else n_pass++;
  endtask

  initial begin
    int k = 0;
    rst = 1'b1;
    send_best_arr = 1'b0;
    out_fifo_wfull_n = 1'b1;
    for (int px = 0; px < 2; px++)
      for (int x = 0; x < 4; x++)
        for (int y = 0; y < 19; y++)
          for (int xi = 0; xi < 4; xi++)
            if (x * 4 + xi < 13) begin
              exp_addr[k] = px * 13 + y * 26 + x * 4 + xi;
              k++;
            end
    test_reset();
    test_full_transfer();
    test_backpressure();
    test_random_backpressure();
    test_extra_start();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
